multicycle_ctrl: RTL and testbench

Parametrised stage sequencer for the multi-cycle RV32I core, the successor to the fixed five-enable `fsm`. It drives one-hot stage enables `if_en`/`id_en`/`ex_en`/`mem_en`/`wb_en` to `if_stage`, `id_stage`, `execution`, `wb_stage` and data memory. Unlike `fsm`, it:
- skips stages per opcode class;
- inserts configurable fetch wait-states;
- handshakes with data memory, with a timeout;
- honours an external stall;
- counts retired instructions.

---
 rtl/multicycle_ctrl.sv | 88 ++++++++
 tb/tb_multicycle_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: opcode-driven stage sequencer with fetch wait-states, memory handshake/timeout, stall and retire counting
module multicycle_ctrl #(
    parameter int IMEM_WAIT   = 0,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic             stall,
    input  logic             mem_ready,
    output logic             if_en,
    output logic             id_en,
    output logic             ex_en,
    output logic             mem_en,
    output logic             wb_en,
    output logic             mem_req,
    output logic             instr_retired,
    output logic             illegal_op,
    output logic             timeout_err,
    output logic             busy,
    output logic [CNT_W-1:0] retire_count
);
    localparam int TW = $clog2(MEM_TIMEOUT + 2);
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    typedef enum logic [2:0] {
        RESET_S, FETCH, FETCH_WAIT, DECODE, EXECUTE, MEMORY, WRITEBACK, ERROR
    } state_t;
    state_t state, state_n;
    logic [7:0]    wait_cnt;
    logic [TW-1:0] to_cnt;
    logic [6:0]    opcode_q;
    logic          known, run, to_hit;
    assign run    = !stall;
    assign known  = opcode inside {7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111, 7'b1100111,
                                   7'b0110111, 7'b0010111, 7'b0110011, 7'b0010011};
    assign to_hit = MEM_TIMEOUT > 0 && !mem_ready && to_cnt == TW'(MEM_TIMEOUT - 1);
    always_ff @(posedge clk) begin
        if (!reset) state <= RESET_S;
        else        state <= state_n;
    end
    always_comb begin
        state_n = state;
        if (run) begin
            case (state)
                RESET_S:    state_n = FETCH;
                FETCH:      state_n = IMEM_WAIT > 0 ? FETCH_WAIT : DECODE;
                FETCH_WAIT: state_n = wait_cnt == 8'(IMEM_WAIT - 1) ? DECODE : FETCH_WAIT;
                DECODE:     state_n = known ? EXECUTE : FETCH;
                EXECUTE:    state_n = (opcode_q == OP_LOAD || opcode_q == OP_STORE) ? MEMORY :
                                      opcode_q == OP_BRANCH ? FETCH : WRITEBACK;
                MEMORY:     state_n = mem_ready ? (opcode_q == OP_LOAD ? WRITEBACK : FETCH) :
                                      to_hit ? ERROR : MEMORY;
                WRITEBACK:  state_n = FETCH;
                default:    state_n = ERROR;
            endcase
        end
    end
    always_comb begin
        if_en         = run && state == FETCH;
        id_en         = run && state == DECODE;
        ex_en         = run && state == EXECUTE;
        mem_en        = run && state == MEMORY;
        wb_en         = run && state == WRITEBACK;
        mem_req       = mem_en;
        instr_retired = wb_en || (ex_en && opcode_q == OP_BRANCH) ||
                        (mem_en && mem_ready && opcode_q == OP_STORE);
        illegal_op    = id_en && !known;
        timeout_err   = state == ERROR;
        busy          = state != RESET_S && state != ERROR;
    end
    // counters run only in their own state, so leaving/entering a state clears them
    always_ff @(posedge clk) begin
        if (!reset) begin
            wait_cnt     <= '0;
            to_cnt       <= '0;
            opcode_q     <= '0;
            retire_count <= '0;
        end else if (run) begin
            wait_cnt <= state == FETCH_WAIT ? wait_cnt + 8'd1 : '0;
            to_cnt   <= state == MEMORY ? to_cnt + TW'(1) : '0;
            if (state == DECODE) opcode_q <= opcode;
            if (instr_retired) retire_count <= retire_count + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: table-driven and directed checks of the stage sequencer
module tb_multicycle_ctrl;
    localparam logic [6:0] OP  = 7'b0110011;
    localparam logic [6:0] LD  = 7'b0000011;
    localparam logic [6:0] ST  = 7'b0100011;
    localparam logic [6:0] BR  = 7'b1100011;
    localparam logic [6:0] BAD = 7'b1111111;
    // {if, id, ex, mem, wb, mem_req, retired, illegal, timeout_err, busy}
    localparam logic [9:0] O_0    = 10'b0000000000;
    localparam logic [9:0] O_IF   = 10'b1000000001;
    localparam logic [9:0] O_ID   = 10'b0100000001;
    localparam logic [9:0] O_IDI  = 10'b0100000101;
    localparam logic [9:0] O_EX   = 10'b0010000001;
    localparam logic [9:0] O_EXR  = 10'b0010001001;
    localparam logic [9:0] O_MEM  = 10'b0001010001;
    localparam logic [9:0] O_MEMR = 10'b0001011001;
    localparam logic [9:0] O_WBR  = 10'b0000101001;
    localparam logic [9:0] O_BSY  = 10'b0000000001;
    localparam logic [9:0] O_ERR  = 10'b0000000010;

    typedef struct {
        logic       rst;
        logic [6:0] op;
        logic       st;
        logic       mr;
        logic [9:0] o;
        logic [3:0] c;
    } vec_t;

    logic       clk = 0, reset = 0, stall = 0, mem_ready = 0;
    logic [6:0] opcode = OP;
    logic if_en, id_en, ex_en, mem_en, wb_en, mem_req, instr_retired, illegal_op, timeout_err, busy;
    logic [3:0] retire_count;
    logic w_if, w_id, w_ex, w_mem, w_wb, w_req, w_ret, w_ill, w_to, w_busy;
    logic [3:0] w_cnt;
    logic [9:0] outs;
    int n_vec = 0, n_bad = 0;
    vec_t tv[$];

    always #5 clk = ~clk;
    assign outs = {if_en, id_en, ex_en, mem_en, wb_en, mem_req, instr_retired, illegal_op, timeout_err, busy};

    multicycle_ctrl #(.IMEM_WAIT(0), .MEM_TIMEOUT(4), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .stall(stall), .mem_ready(mem_ready),
        .if_en(if_en), .id_en(id_en), .ex_en(ex_en), .mem_en(mem_en), .wb_en(wb_en),
        .mem_req(mem_req), .instr_retired(instr_retired), .illegal_op(illegal_op),
        .timeout_err(timeout_err), .busy(busy), .retire_count(retire_count)
    );

    multicycle_ctrl #(.IMEM_WAIT(2), .MEM_TIMEOUT(4), .CNT_W(4)) dut_w (
        .clk(clk), .reset(reset), .opcode(opcode), .stall(stall), .mem_ready(mem_ready),
        .if_en(w_if), .id_en(w_id), .ex_en(w_ex), .mem_en(w_mem), .wb_en(w_wb),
        .mem_req(w_req), .instr_retired(w_ret), .illegal_op(w_ill),
        .timeout_err(w_to), .busy(w_busy), .retire_count(w_cnt)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic add(input logic r, input logic [6:0] op, input logic st, input logic mr,
                       input logic [9:0] o, input logic [3:0] c);
        vec_t v;
        v.rst = r; v.op = op; v.st = st; v.mr = mr; v.o = o; v.c = c;
        tv.push_back(v);
    endtask

    task automatic do_reset;
        reset = 0;
        tick;
        reset = 1;
    endtask

    initial begin
        int k, n;
        logic [4:0] w_exp[7];
        // reset, OP
        add(0, OP, 0, 1, O_0, 0);    add(1, OP, 0, 1, O_0, 0);
        add(1, OP, 0, 1, O_IF, 0);   add(1, OP, 0, 1, O_ID, 0);
        add(1, OP, 0, 1, O_EX, 0);   add(1, OP, 0, 1, O_WBR, 0);
        // load, mem_ready in 3rd MEMORY cycle
        add(1, LD, 0, 0, O_IF, 1);   add(1, LD, 0, 0, O_ID, 1);
        add(1, LD, 0, 0, O_EX, 1);   add(1, LD, 0, 0, O_MEM, 1);
        add(1, LD, 0, 0, O_MEM, 1);  add(1, LD, 0, 1, O_MEM, 1);
        add(1, LD, 0, 1, O_WBR, 1);
        // store then branch
        add(1, ST, 0, 1, O_IF, 2);   add(1, ST, 0, 1, O_ID, 2);
        add(1, ST, 0, 1, O_EX, 2);   add(1, ST, 0, 1, O_MEMR, 2);
        add(1, BR, 0, 1, O_IF, 3);   add(1, BR, 0, 1, O_ID, 3);
        add(1, BR, 0, 1, O_EXR, 3);
        // unknown opcode
        add(1, BAD, 0, 1, O_IF, 4);  add(1, BAD, 0, 1, O_IDI, 4);
        // stall during EXECUTE
        add(1, OP, 0, 1, O_IF, 4);   add(1, OP, 0, 1, O_ID, 4);
        add(1, OP, 1, 1, O_BSY, 4);  add(1, OP, 1, 1, O_BSY, 4);
        add(1, OP, 1, 1, O_BSY, 4);  add(1, OP, 0, 1, O_EX, 4);
        add(1, OP, 0, 1, O_WBR, 4);
        // stall during MEMORY must freeze the timeout counter
        add(1, LD, 0, 0, O_IF, 5);   add(1, LD, 0, 0, O_ID, 5);
        add(1, LD, 0, 0, O_EX, 5);   add(1, LD, 0, 0, O_MEM, 5);
        add(1, LD, 1, 1, O_BSY, 5);  add(1, LD, 1, 0, O_BSY, 5);
        add(1, LD, 0, 0, O_MEM, 5);  add(1, LD, 0, 0, O_MEM, 5);
        add(1, LD, 0, 1, O_MEM, 5);  add(1, LD, 0, 1, O_WBR, 5);
        // timeout
        add(1, LD, 0, 0, O_IF, 6);   add(1, LD, 0, 0, O_ID, 6);
        add(1, LD, 0, 0, O_EX, 6);   add(1, LD, 0, 0, O_MEM, 6);
        add(1, LD, 0, 0, O_MEM, 6);  add(1, LD, 0, 0, O_MEM, 6);
        add(1, LD, 0, 0, O_MEM, 6);  add(1, LD, 0, 0, O_ERR, 6);
        add(1, LD, 1, 1, O_ERR, 6);  add(0, LD, 0, 0, O_ERR, 6);
        add(1, ST, 0, 0, O_0, 0);    add(1, ST, 0, 0, O_IF, 0);
        // reset mid-MEMORY
        add(1, ST, 0, 0, O_ID, 0);   add(1, ST, 0, 0, O_EX, 0);
        add(0, ST, 0, 0, O_MEM, 0);  add(1, ST, 0, 0, O_0, 0);
        add(1, ST, 0, 0, O_IF, 0);

        tick;
        tick;
        foreach (tv[i]) begin
            reset = tv[i].rst; opcode = tv[i].op; stall = tv[i].st; mem_ready = tv[i].mr;
            #1;
            chk($sformatf("vec%0d_outs", i), 32'(outs), 32'(tv[i].o));
            chk($sformatf("vec%0d_count", i), 32'(retire_count), 32'(tv[i].c));
            tick;
        end

        // IMEM_WAIT=2 instance: two wait cycles between fetch and decode
        w_exp = '{5'b00000, 5'b10000, 5'b00000, 5'b00000, 5'b01000, 5'b00100, 5'b00001};
        opcode = OP; stall = 0; mem_ready = 1;
        do_reset;
        for (int i = 0; i < 7; i++) begin
            #1;
            chk($sformatf("wait_cyc%0d", i), 32'({w_if, w_id, w_ex, w_mem, w_wb}), 32'(w_exp[i]));
            tick;
        end
        #1;
        chk("wait_refetch", 32'(w_if), 1);

        // 4-bit retire counter wraps after 16
        do_reset;
        tick;
        for (int i = 1; i <= 17; i++) begin
            chk($sformatf("wrap_if%0d", i), 32'(if_en), 1);
            tick; tick; tick;
            chk($sformatf("wrap_ret%0d", i), 32'(instr_retired), 1);
            tick;
            chk($sformatf("wrap_cnt%0d", i), 32'(retire_count), 32'(i % 16));
        end

        // timeout: mem_req for exactly MEM_TIMEOUT cycles, then ERROR until reset
        opcode = LD; mem_ready = 0;
        do_reset;
        k = 0;
        while (!mem_req && k < 10) begin
            tick;
            k++;
        end
        chk("to_reach_mem", 32'(mem_req), 1);
        n = 0;
        while (mem_req && n < 20) begin
            n++;
            tick;
        end
        chk("to_req_cycles", n, 4);
        for (int i = 0; i < 20; i++) begin
            mem_ready = i[0];
            #1;
            chk($sformatf("err_hold%0d", i), 32'(outs), 32'(O_ERR));
            tick;
        end
        do_reset;
        #1;
        chk("err_reset_outs", 32'(outs), 32'(O_0));
        chk("err_reset_cnt", 32'(retire_count), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
